word_tx_arbiter: RTL and testbench

WORD_TX_ARBITER -- requirements
Module: word_tx_arbiter

---
 rtl/word_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_word_tx_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/word_tx_arbiter.sv
// Two-requester round-robin arbiter that serialises 16-bit words into two
// byte transfers on a UART transmitter start/busy handshake.
module word_tx_arbiter #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        req0,
  input  logic [15:0] word0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] word1,
  output logic        ack1,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic [15:0] word_count
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SEND      = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        byte_idx_q, byte_idx_d;
  logic [15:0] word_q, word_d;
  logic        last_grant_q, last_grant_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [15:0] word_count_q, word_count_d;

  logic grant1;
  logic hi_sel;

  // On a tie the requester not served last wins; last_grant resets to 1 so 0 wins first.
  assign grant1 = (req0 && req1) ? ~last_grant_q : req1;
  assign hi_sel = LSB_FIRST ? byte_idx_q : ~byte_idx_q;

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    last_grant_d = last_grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    tx_start_d   = 1'b0;
    tx_byte_d    = tx_byte_q;
    word_count_d = word_count_q;
    if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            word_d       = grant1 ? word1 : word0;
            ack0_d       = ~grant1;
            ack1_d       = grant1;
            last_grant_d = grant1;
            byte_idx_d   = 1'b0;
            state_d      = S_SEND;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_byte_d  = hi_sel ? word_q[15:8] : word_q[7:0];
            state_d    = S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (tx_busy) state_d = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            if (!byte_idx_q) begin
              byte_idx_d = 1'b1;
              state_d    = S_SEND;
            end else begin
              word_count_d = word_count_q + 16'd1;
              state_d      = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pulse registers load their _d every edge, so they clear even when ce is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= 1'b0;
      word_q       <= 16'h0000;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_byte_q    <= 8'h00;
      word_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      tx_start_q   <= tx_start_d;
      tx_byte_q    <= tx_byte_d;
      word_count_q <= word_count_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign tx_start   = tx_start_q;
  assign tx_byte    = tx_byte_q;
  assign busy       = (state_q != S_IDLE);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_word_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected bytes/acks, negedge monitors pop and
// compare; an LSB-first and an MSB-first instance share all inputs.
module tb_word_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] word0 = 16'h0, word1 = 16'h0;
  logic        tx_busy = 1'b0;
  logic        ack0, ack1, tx_start, busy;
  logic [7:0]  tx_byte;
  logic [15:0] word_count;
  logic        m_ack0, m_ack1, m_tx_start, m_busy;
  logic [7:0]  m_tx_byte;
  logic [15:0] m_word_count;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int busy_len = 10;
  int bcnt = 0;
  bit hold_busy = 1'b0;
  bit ce_toggle = 1'b0;
  bit prev_start = 1'b0;

  logic [7:0] exp_lsb[$];
  logic [7:0] exp_msb[$];
  int         exp_ack[$];

  word_tx_arbiter #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .ce(ce), .req0(req0), .word0(word0), .ack0(ack0),
    .req1(req1), .word1(word1), .ack1(ack1), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_byte(tx_byte), .busy(busy), .word_count(word_count));

  word_tx_arbiter #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .ce(ce), .req0(req0), .word0(word0), .ack0(m_ack0),
    .req1(req1), .word1(word1), .ack1(m_ack1), .tx_busy(tx_busy),
    .tx_start(m_tx_start), .tx_byte(m_tx_byte), .busy(m_busy), .word_count(m_word_count));

  always #5 clk = ~clk;

  // Transmitter model: busy for busy_len cycles after each start, or held by hold_busy.
  initial forever begin
    @(negedge clk);
    if (tx_start) bcnt = busy_len;
    else if (bcnt > 0) bcnt--;
    tx_busy = (bcnt > 0) || hold_busy;
  end

  initial forever begin
    @(posedge clk);
    #2;
    ce = ce_toggle ? ~ce : 1'b1;
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      n_start++;
      checks++;
      if (exp_lsb.size() == 0) begin
        errors++; $display("FAIL lsb_byte unexpected tx_start byte=%h", tx_byte);
      end else begin
        logic [7:0] e;
        e = exp_lsb.pop_front();
        if (tx_byte !== e) begin errors++; $display("FAIL lsb_byte got=%h exp=%h", tx_byte, e); end
      end
      checks++;
      if (prev_start) begin errors++; $display("FAIL tx_start_stretch got=1 exp=0"); end
    end
    if (m_tx_start) begin
      checks++;
      if (exp_msb.size() == 0) begin
        errors++; $display("FAIL msb_byte unexpected tx_start byte=%h", m_tx_byte);
      end else begin
        logic [7:0] e;
        e = exp_msb.pop_front();
        if (m_tx_byte !== e) begin errors++; $display("FAIL msb_byte got=%h exp=%h", m_tx_byte, e); end
      end
    end
    if (ack0 || ack1) begin
      checks++;
      if (ack0 && ack1) begin errors++; $display("FAIL ack_both got=11 exp=one-hot"); end
      else if (exp_ack.size() == 0) begin errors++; $display("FAIL ack unexpected ack1=%0b", ack1); end
      else begin
        int e;
        e = exp_ack.pop_front();
        if (int'(ack1) != e) begin errors++; $display("FAIL ack_order got=%0d exp=%0d", ack1, e); end
      end
    end
    prev_start = tx_start;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got=%h exp=%h", nm, act, exp); end
  endtask

  task automatic exp_word(input logic [7:0] first_lsb, input logic [7:0] second_lsb);
    exp_lsb.push_back(first_lsb); exp_lsb.push_back(second_lsb);
    exp_msb.push_back(second_lsb); exp_msb.push_back(first_lsb);
  endtask

  task automatic wait_ack(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin @(negedge clk); got = ack0 || ack1; end
    if (!got) begin checks++; errors++; $display("FAIL %s ack timeout got=0 exp=1", nm); end
  endtask

  task automatic wait_idle(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin @(negedge clk); got = !busy; end
    if (!got) begin checks++; errors++; $display("FAIL %s idle timeout got=busy exp=idle", nm); end
  endtask

  task automatic send0(input logic [15:0] w, input string nm);
    word0 = w; req0 = 1'b1; exp_ack.push_back(0);
    wait_ack(nm);
    req0 = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_count", word_count, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_pulses", {ack0, ack1, tx_start}, 0);
    @(negedge clk); rst = 1'b0;

    // Single word, LSB first
    exp_word(8'h5A, 8'hA5);
    send0(16'hA55A, "single");
    wait_idle("single");
    chk("single_count", word_count, 1);
    chk("single_busy", busy, 0);

    // Tie from reset: requester 0 then 1
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    word0 = 16'h1111; word1 = 16'h2222;
    exp_word(8'h11, 8'h11); exp_word(8'h22, 8'h22);
    exp_ack.push_back(0); exp_ack.push_back(1);
    req0 = 1'b1; req1 = 1'b1;
    wait_ack("rr0"); req0 = 1'b0;
    wait_ack("rr1"); req1 = 1'b0;
    wait_idle("rr");
    chk("rr_count", word_count, 2);

    // 0xBEEF: LSB instance EF,BE; MSB instance BE,EF
    exp_word(8'hEF, 8'hBE);
    send0(16'hBEEF, "beef");
    wait_idle("beef");
    chk("beef_count", word_count, 3);

    // Transmitter busy on entry to SEND, then ce toggling
    hold_busy = 1'b1;
    @(negedge clk);
    exp_word(8'h34, 8'h12);
    begin
      int n0;
      n0 = n_start;
      send0(16'h1234, "hold");
      repeat (20) @(negedge clk);
      chk("hold_no_start", n_start, n0);
      ce_toggle = 1'b1; hold_busy = 1'b0;
      wait_idle("ce_toggle");
      ce_toggle = 1'b0;
      chk("ce_toggle_starts", n_start, n0 + 2);
    end
    chk("ce_count", word_count, 4);
    repeat (15) @(negedge clk);

    // Reset in WAIT_DONE of first byte
    exp_lsb.push_back(8'h88); exp_msb.push_back(8'h77);
    begin
      int n0;
      bit got = 1'b0;
      n0 = n_start;
      send0(16'h7788, "abort");
      for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); got = (n_start != n0); end
      if (!got) begin checks++; errors++; $display("FAIL abort start timeout got=0 exp=1"); end
      repeat (3) @(negedge clk);
      chk("abort_in_flight", {busy, tx_busy}, 2'b11);
      rst = 1'b1; #1;
      chk("abort_busy", busy, 0);
      chk("abort_count", word_count, 0);
      chk("abort_tx_byte", tx_byte, 0);
      chk("abort_pulses", {ack0, ack1, tx_start}, 0);
      repeat (2) @(negedge clk); rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("abort_no_resend", n_start, n0 + 1);
      chk("abort_count_after", word_count, 0);
    end

    // Counter wrap
    @(negedge clk); force dut.word_count_q = 16'hFFFF;
    repeat (2) @(negedge clk); release dut.word_count_q;
    @(negedge clk);
    chk("wrap_preset", word_count, 16'hFFFF);
    exp_word(8'h02, 8'h01);
    send0(16'h0102, "wrap");
    wait_idle("wrap");
    chk("wrap_count", word_count, 0);

    repeat (5) @(negedge clk);
    chk("lsb_queue_empty", exp_lsb.size(), 0);
    chk("msb_queue_empty", exp_msb.size(), 0);
    chk("ack_queue_empty", exp_ack.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
